hist_blkrcv: RTL
================

// Module: hist_blkrcv
// PURPOSE
//  Reader/consumer end of the give/have/dout block interface driven by the trigger-history and channel block
//  producers. Polls NSRC producers round-robin, takes exactly one complete block per grant (length from the
//  control word, CW), and forwards it to a downstream FIFO. Sits in the channel FPGA between producers and link.
// PARAMETERS
//  NSRC    4      number of producer ports (1..8)
//  TMOBITS 8      mid-block stall timeout counter width; timeout = 2**TMOBITS-1 cycles without have
// PORTS
//  clk      in   1          master clock
//  reset    in   1          synchronous, active-high reset
//  give     out  NSRC       per-source read request (combinational from state, at most one bit high)
//  have     in   NSRC       per-source word-valid; word on din slice is consumed in any cycle give&have
//  din      in   16*NSRC    source data, slice i = din[16*i+15:16*i], valid in the same cycle as have[i]
//  afull    in   1          downstream has < 512 free words; no new block is started while high
//  dout     out  16         forwarded word (registered)
//  dvalid   out  1          dout valid strobe
//  dsof     out  1          marks the CW word of a forwarded block
//  dsrc     out  3          source index of the block currently forwarded
//  cw_err   out  16         count of rejected CWs (saturating)
//  tmo_err  out  16         count of mid-block timeouts (saturating)
// BEHAVIOUR
//  Reset: give=0, dout=0, dvalid=0, dsof=0, dsrc=0, counters=0, pointer cur=0, state ST_POLL.
//  Word format: CW = {1'b1, CC[1:0], 4'h0, L[8:0]}; L = number of words that follow the CW (0..511).
//  ST_POLL: give[cur]=~afull. If afull: hold. If have[cur]: word consumed this cycle.
//    - din[15]=1: forward CW (dsof=1), rem<=L, tmo<=0; L==0 -> cur<=cur+1 (mod NSRC), stay ST_POLL; else ST_BODY.
//    - din[15]=0: word discarded, cw_err++, stay on same source (resync: keep polling until a CW is seen).
//    If ~have[cur] and ~afull: cur<=cur+1 (mod NSRC) next cycle; empty sources cost 1 cycle each.
//  ST_BODY: give[cur]=1 regardless of afull (room reserved at CW). On have: forward word, rem--, tmo<=0;
//    rem==1 on accept -> give drops combinationally next cycle, cur<=cur+1, ST_POLL (never over-reads into the
//    following block). On ~have: tmo++; tmo all-ones -> tmo_err++, give=0, cur<=cur+1, ST_POLL (block truncated).
//  Body words are forwarded unchanged (bit15 not checked). Output latency: din -> dout/dvalid = 1 cycle.
//  dvalid per cycle = registered (give&have) for valid-CW or body words; rejected CWs never produce dvalid.
//  Round-robin fairness: after any block (or timeout) the pointer advances; a source cannot get two grants in a row
//  unless it is the only one with data.
//  afull rising mid-block has no effect; afull sampled only in ST_POLL.
//  Reset mid-block: block abandoned immediately, give=0 next cycle, no further dvalid; producer keeps its
//  pointer so the first word polled after reset may be mid-block -> handled by CW resync (counts cw_err).
//  Counters saturate at 16'hFFFF; rem is 9 bits, tmo TMOBITS bits.
// STRUCTURE
//  Shared package: CW_FLAG bit position, L field [8:0], MAXBLK=512, state encodings ST_POLL/ST_BODY.
//  One natural sub-module: rr_ptr (NSRC round-robin pointer with advance strobe). Data mux is a plain indexed slice.
// TESTING
//  1. Src0 holds block CW=16'h8005 + 5 words, others empty -> 6 dvalid cycles, dsof on first, dsrc=0, give[0] low
//     right after 6th word even though src0 has a 2nd block queued.
//  2. Src1 and src3 each one block L=3 -> forwarded src1 then src3, no gap inside a block, cw_err=tmo_err=0.
//  3. Src2 first word 16'h1234 then CW 16'h8002 +2 words -> 1234 dropped, cw_err=1, 3-word block forwarded.
//  4. Src0 CW L=4, have low after 2nd body word for 255 cycles -> tmo_err=1, give[0] drops, poll moves to src1.
//  5. afull=1 with all sources loaded -> give=0, dvalid=0; afull mid-block of L=10 -> all 11 words forwarded.
//  6. CW 16'h8000 (L=0) -> single dvalid with dsof; reset asserted at body word 3 of L=8 -> dvalid=0 next cycle.

Source files
------------

// File: rtl/hist_blkrcv_pkg.sv
// Shared definitions for the history/channel block receiver: control-word layout,
// block size limit and the reader state encoding.
package hist_blkrcv_pkg;

    localparam int CW_FLAG = 15;
    localparam int LEN_MSB = 8;
    localparam int MAXBLK  = 512;
    localparam int LEN_W   = $clog2(MAXBLK);
    localparam int SRC_W   = 3;

    typedef enum logic {
        ST_POLL = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hist_blkrcv_rr_ptr.sv
// Round-robin source pointer: steps to the next producer port whenever advance is
// strobed, wrapping at NSRC.
module hist_blkrcv_rr_ptr
    import hist_blkrcv_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [SRC_W-1:0] cur
);

    localparam logic [SRC_W-1:0] LAST = SRC_W'(NSRC - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= '0;
        end else if (advance) begin
            cur <= (cur == LAST) ? '0 : cur + 1'b1;
        end
    end

endmodule

// File: rtl/hist_blkrcv.sv
// Block reader: polls NSRC give/have producers round-robin, takes one whole block per
// grant and forwards it with a one-cycle registered latency, counting bad CWs and stalls.
module hist_blkrcv
    import hist_blkrcv_pkg::*;
#(
    parameter int NSRC    = 4,
    parameter int TMOBITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [NSRC-1:0]      give,
    input  logic [NSRC-1:0]      have,
    input  logic [16*NSRC-1:0]   din,
    input  logic                 afull,
    output logic [15:0]          dout,
    output logic                 dvalid,
    output logic                 dsof,
    output logic [2:0]           dsrc,
    output logic [15:0]          cw_err,
    output logic [15:0]          tmo_err
);

    // Last stalled cycle before the counter would reach all-ones.
    localparam logic [TMOBITS-1:0] TMO_LAST = {{(TMOBITS-1){1'b1}}, 1'b0};

    state_t             state;
    state_t             state_nx;
    logic [SRC_W-1:0]   cur;
    logic [LEN_W-1:0]   rem;
    logic [LEN_W-1:0]   rem_nx;
    logic [TMOBITS-1:0] tmo;
    logic [TMOBITS-1:0] tmo_nx;
    logic               advance;
    logic               cur_have;
    logic [15:0]        word;
    logic               fwd;
    logic               cw_bad;
    logic               tmo_hit;

    hist_blkrcv_rr_ptr #(.NSRC(NSRC)) u_rr_ptr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .cur     (cur)
    );

    // Body reads ignore afull because room for the whole block was checked at the CW.
    always_comb begin
        give     = '0;
        cur_have = 1'b0;
        word     = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cur == SRC_W'(i)) begin
                cur_have = have[i];
                word     = din[16*i +: 16];
                give[i]  = ~reset & ((state == ST_BODY) | ~afull);
            end
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        tmo_nx   = tmo;
        advance  = 1'b0;
        fwd      = 1'b0;
        cw_bad   = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            ST_POLL: begin
                if (!afull) begin
                    if (cur_have) begin
                        if (word[CW_FLAG]) begin
                            fwd    = 1'b1;
                            rem_nx = word[LEN_MSB:0];
                            tmo_nx = '0;
                            if (word[LEN_MSB:0] == '0) begin
                                advance = 1'b1;
                            end else begin
                                state_nx = ST_BODY;
                            end
                        end else begin
                            cw_bad = 1'b1;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (cur_have) begin
                    fwd    = 1'b1;
                    rem_nx = rem - 1'b1;
                    tmo_nx = '0;
                    if (rem == LEN_W'(1)) begin
                        advance  = 1'b1;
                        state_nx = ST_POLL;
                    end
                end else begin
                    tmo_nx = tmo + 1'b1;
                    if (tmo == TMO_LAST) begin
                        tmo_hit  = 1'b1;
                        advance  = 1'b1;
                        state_nx = ST_POLL;
                    end
                end
            end
            default: state_nx = ST_POLL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_POLL;
            rem     <= '0;
            tmo     <= '0;
            dout    <= '0;
            dvalid  <= 1'b0;
            dsof    <= 1'b0;
            dsrc    <= '0;
            cw_err  <= '0;
            tmo_err <= '0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            tmo    <= tmo_nx;
            dvalid <= fwd;
            dsof   <= fwd & (state == ST_POLL);
            if (fwd) begin
                dout <= word;
            end
            if (fwd && state == ST_POLL) begin
                dsrc <= cur;
            end
            if (cw_bad) begin
                cw_err <= sat_inc(cw_err);
            end
            if (tmo_hit) begin
                tmo_err <= sat_inc(tmo_err);
            end
        end
    end

endmodule
